// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the L1-to-L2 line-port arbiter.
package cache_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 256;
    localparam int OFF_W  = 5;

    typedef logic [ADDR_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_block;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } lc3b_arb_state;

    typedef struct packed {
        logic      read;
        logic      write;
        lc3b_word  address;
        lc3b_block wdata;
    } lc3b_line_req;

    localparam lc3b_word LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    function automatic lc3b_word line_align(input lc3b_word addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// One line-granular memory port; the requester is master, the responder slave.
interface cache_arbiter_if;
    import cache_arbiter_pkg::*;

    logic      read;
    logic      write;
    lc3b_word  address;
    lc3b_block wdata;
    lc3b_block rdata;
    logic      resp;

    modport master (output read, write, address, wdata, input rdata, resp);
    modport slave  (input read, write, address, wdata, output rdata, resp);

endinterface

// File: rtl/cache_arb_grant_sel.sv
// Combinational winner pick between I- and D-cache requests.
// CACHE_ARB_RR_EN selects round-robin tie-break; otherwise D-cache always wins ties.
module cache_arb_grant_sel
    import cache_arbiter_pkg::*;
(
    input  logic          i_req_i,
    input  logic          i_req_d,
`ifdef CACHE_ARB_RR_EN
    input  lc3b_arb_state i_last_grant,
`endif
    output lc3b_arb_state o_grant
);

    // Winner selection; a tie is the only case where the builds differ
    always_comb begin
        o_grant = ARB_IDLE;
        if (i_req_i && i_req_d) begin
`ifdef CACHE_ARB_RR_EN
            if (i_last_grant == ARB_D) begin
                o_grant = ARB_I;
            end else begin
                o_grant = ARB_D;
            end
`else
            o_grant = ARB_D;
`endif
        end else if (i_req_d) begin
            o_grant = ARB_D;
        end else if (i_req_i) begin
            o_grant = ARB_I;
        end else begin
            o_grant = ARB_IDLE;
        end
    end

endmodule

// File: rtl/cache_arbiter_chk.sv
// Simulation-only protocol checks for cache_arbiter: illegal read+write and stray mem_resp.
module cache_arbiter_chk
    import cache_arbiter_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    input logic          i_ic_read,
    input logic          i_ic_write,
    input logic          i_dc_read,
    input logic          i_dc_write,
    input lc3b_arb_state i_state,
    input logic          i_mem_resp
);

    a_ic_rw: assert property (@(posedge clk) disable iff (!rst_n)
        (i_state == ARB_IDLE) |-> !(i_ic_read && i_ic_write))
        else $warning("cache_arbiter: I-cache read and write together");

    a_dc_rw: assert property (@(posedge clk) disable iff (!rst_n)
        (i_state == ARB_IDLE) |-> !(i_dc_read && i_dc_write))
        else $warning("cache_arbiter: D-cache read and write together");

    a_idle_resp: assert property (@(posedge clk) disable iff (!rst_n)
        (i_state == ARB_IDLE) |-> !i_mem_resp)
        else $warning("cache_arbiter: mem_resp with no transaction open");

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line port to L2/pmem between I-cache and D-cache; the winner's request is
// latched and replayed until mem_resp. Optional round-robin tie-break via CACHE_ARB_RR_EN.
module cache_arbiter
    import cache_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  ic_bus,
    cache_arbiter_if.slave  dc_bus,
    cache_arbiter_if.master mem_bus
);

    lc3b_arb_state r_state;
    lc3b_line_req  r_req;
    lc3b_arb_state w_grant;
    lc3b_line_req  w_sel;
    logic          w_req_i;
    logic          w_req_d;

    assign w_req_i = ic_bus.read | ic_bus.write;
    assign w_req_d = dc_bus.read | dc_bus.write;

`ifdef CACHE_ARB_RR_EN
    lc3b_arb_state r_last_grant;

    // Remember the most recent winner for the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= ARB_I;
        end else if ((r_state == ARB_IDLE) && (w_grant != ARB_IDLE)) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    cache_arb_grant_sel u_grant_sel (
        .i_req_i      (w_req_i),
        .i_req_d      (w_req_d),
`ifdef CACHE_ARB_RR_EN
        .i_last_grant (r_last_grant),
`endif
        .o_grant      (w_grant)
    );

    // Mux the winning cache's request toward the latch
    always_comb begin
        w_sel = '0;
        if (w_grant == ARB_D) begin
            w_sel = '{read: dc_bus.read, write: dc_bus.write,
                      address: dc_bus.address, wdata: dc_bus.wdata};
        end else begin
            w_sel = '{read: ic_bus.read, write: ic_bus.write,
                      address: ic_bus.address, wdata: ic_bus.wdata};
        end
    end

    // Arbitration FSM; a write request overrides a simultaneous read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_req   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant != ARB_IDLE) begin
                        r_state       <= w_grant;
                        r_req.read    <= w_sel.read & ~w_sel.write;
                        r_req.write   <= w_sel.write;
                        r_req.address <= line_align(w_sel.address);
                        r_req.wdata   <= w_sel.wdata;
                    end
                end
                ARB_I, ARB_D: begin
                    if (mem_bus.resp) begin
                        r_state     <= ARB_IDLE;
                        r_req.read  <= 1'b0;
                        r_req.write <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ARB_IDLE;
                    r_req.read  <= 1'b0;
                    r_req.write <= 1'b0;
                end
            endcase
        end
    end

    assign mem_bus.read    = r_req.read;
    assign mem_bus.write   = r_req.write;
    assign mem_bus.address = r_req.address;
    assign mem_bus.wdata   = r_req.wdata;

    // Response reaches only the owner, in the same cycle as mem_resp
    assign ic_bus.rdata = mem_bus.rdata;
    assign dc_bus.rdata = mem_bus.rdata;
    assign ic_bus.resp  = mem_bus.resp & (r_state == ARB_I);
    assign dc_bus.resp  = mem_bus.resp & (r_state == ARB_D);

    cache_arbiter_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ic_read  (ic_bus.read),
        .i_ic_write (ic_bus.write),
        .i_dc_read  (dc_bus.read),
        .i_dc_write (dc_bus.write),
        .i_state    (r_state),
        .i_mem_resp (mem_bus.resp)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; expectations follow CACHE_ARB_RR_EN when defined.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    lc3b_block pat_ab;
    lc3b_block pat_d;
    lc3b_block pat_1;
    lc3b_block pat_2;
    lc3b_block pat_3;

    cache_arbiter_if ic_if ();
    cache_arbiter_if dc_if ();
    cache_arbiter_if mem_if ();

    cache_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ic_bus  (ic_if),
        .dc_bus  (dc_if),
        .mem_bus (mem_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ic_if.read = 1'b0; ic_if.write = 1'b0; ic_if.address = 16'h0000; ic_if.wdata = '0;
        dc_if.read = 1'b0; dc_if.write = 1'b0; dc_if.address = 16'h0000; dc_if.wdata = '0;
        mem_if.resp = 1'b0; mem_if.rdata = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_if.read, mem_if.write, ic_if.resp, dc_if.resp} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes actual=%b required=0000",
                     {mem_if.read, mem_if.write, ic_if.resp, dc_if.resp});
        end
        checks++;
        if (mem_if.address !== 16'h0000 || mem_if.wdata !== 256'h0) begin
            failures++;
            $display("FAIL reset_latch actual_addr=%h required=0000", mem_if.address);
        end
        checks++;
        if (dut.r_state !== ARB_IDLE) begin
            failures++;
            $display("FAIL reset_state actual=%0d required=%0d", dut.r_state, ARB_IDLE);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lone_i_read;
        ic_if.read = 1'b1;
        ic_if.address = 16'h1234;
        tick();
        checks++;
        if ({mem_if.read, mem_if.write} !== 2'b10 || mem_if.address !== 16'h1220) begin
            failures++;
            $display("FAIL lone_i_strobe actual=%b/%h required=10/1220",
                     {mem_if.read, mem_if.write}, mem_if.address);
        end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++;
            if ({mem_if.read, ic_if.resp, dc_if.resp} !== 3'b100) begin
                failures++;
                $display("FAIL lone_i_hold cycle=%0d actual=%b required=100",
                         c, {mem_if.read, ic_if.resp, dc_if.resp});
            end
        end
        tick();
        mem_if.rdata = pat_ab;
        mem_if.resp = 1'b1;
        #1;
        checks++;
        if ({ic_if.resp, dc_if.resp} !== 2'b10 || ic_if.rdata !== pat_ab) begin
            failures++;
            $display("FAIL lone_i_resp actual=%b required=10", {ic_if.resp, dc_if.resp});
        end
        tick();
        mem_if.resp = 1'b0;
        ic_if.read = 1'b0;
        #1;
        checks++;
        if (dut.r_state !== ARB_IDLE || {mem_if.read, ic_if.resp} !== 2'b00) begin
            failures++;
            $display("FAIL lone_i_done actual_state=%0d required=%0d", dut.r_state, ARB_IDLE);
        end
    endtask

    task automatic test_tie;
        ic_if.read = 1'b1; ic_if.address = 16'h0100;
        dc_if.write = 1'b1; dc_if.address = 16'h0040; dc_if.wdata = pat_d;
        tick();
        checks++;
        if ({mem_if.read, mem_if.write} !== 2'b01 || mem_if.address !== 16'h0040 ||
            mem_if.wdata !== pat_d) begin
            failures++;
            $display("FAIL tie_d_first actual=%b/%h required=01/0040",
                     {mem_if.read, mem_if.write}, mem_if.address);
        end
        tick();
        tick();
        mem_if.resp = 1'b1;
        #1;
        checks++;
        if ({ic_if.resp, dc_if.resp} !== 2'b01) begin
            failures++;
            $display("FAIL tie_d_resp actual=%b required=01", {ic_if.resp, dc_if.resp});
        end
        tick();
        mem_if.resp = 1'b0;
        dc_if.write = 1'b0;
        #1;
        checks++;
        if ({mem_if.read, mem_if.write} !== 2'b00) begin
            failures++;
            $display("FAIL tie_bubble actual=%b required=00", {mem_if.read, mem_if.write});
        end
        tick();
        checks++;
        if ({mem_if.read, mem_if.write} !== 2'b10 || mem_if.address !== 16'h0100) begin
            failures++;
            $display("FAIL tie_i_second actual=%b/%h required=10/0100",
                     {mem_if.read, mem_if.write}, mem_if.address);
        end
        mem_if.resp = 1'b1;
        #1;
        checks++;
        if ({ic_if.resp, dc_if.resp} !== 2'b10) begin
            failures++;
            $display("FAIL tie_i_resp actual=%b required=10", {ic_if.resp, dc_if.resp});
        end
        tick();
        mem_if.resp = 1'b0;
        ic_if.read = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic           exp_d;
        logic [15:0]    exp_addr;
        ic_if.read = 1'b1; ic_if.address = 16'h0300;
        dc_if.read = 1'b1; dc_if.address = 16'h0500;
        for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            exp_addr = exp_d ? 16'h0500 : 16'h0300;
            tick();
            checks++;
            if (mem_if.read !== 1'b1 || mem_if.address !== exp_addr) begin
                failures++;
                $display("FAIL b2b_grant k=%0d actual=%b/%h required=1/%h",
                         k, mem_if.read, mem_if.address, exp_addr);
            end
            mem_if.resp = 1'b1;
            #1;
            checks++;
            if ({ic_if.resp, dc_if.resp} !== {~exp_d, exp_d}) begin
                failures++;
                $display("FAIL b2b_resp k=%0d actual=%b required=%b",
                         k, {ic_if.resp, dc_if.resp}, {~exp_d, exp_d});
            end
            tick();
            mem_if.resp = 1'b0;
            #1;
            checks++;
            if (mem_if.read !== 1'b0) begin
                failures++;
                $display("FAIL b2b_bubble k=%0d actual=%b required=0", k, mem_if.read);
            end
        end
        ic_if.read = 1'b0;
        dc_if.read = 1'b0;
        tick();
    endtask

    task automatic test_latch_stability;
        dc_if.read = 1'b1; dc_if.address = 16'h2345; dc_if.wdata = pat_1;
        tick();
        checks++;
        if (dut.r_state !== ARB_D || mem_if.address !== 16'h2340 || mem_if.wdata !== pat_1) begin
            failures++;
            $display("FAIL latch_grant actual=%h required=2340", mem_if.address);
        end
        dc_if.address = 16'hFFFF; dc_if.wdata = pat_2;
        dc_if.read = 1'b0; dc_if.write = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({mem_if.read, mem_if.write} !== 2'b10 || mem_if.address !== 16'h2340 ||
                mem_if.wdata !== pat_1) begin
                failures++;
                $display("FAIL latch_hold c=%0d actual=%b/%h required=10/2340",
                         c, {mem_if.read, mem_if.write}, mem_if.address);
            end
        end
        mem_if.resp = 1'b1;
        #1;
        checks++;
        if ({ic_if.resp, dc_if.resp} !== 2'b01) begin
            failures++;
            $display("FAIL latch_resp actual=%b required=01", {ic_if.resp, dc_if.resp});
        end
        tick();
        mem_if.resp = 1'b0;
        dc_if.write = 1'b0;
        tick();
    endtask

    task automatic test_illegal;
        mem_if.resp = 1'b1;
        #1;
        checks++;
        if ({ic_if.resp, dc_if.resp} !== 2'b00) begin
            failures++;
            $display("FAIL spurious_resp actual=%b required=00", {ic_if.resp, dc_if.resp});
        end
        tick();
        mem_if.resp = 1'b0;
        #1;
        checks++;
        if (dut.r_state !== ARB_IDLE || {mem_if.read, mem_if.write} !== 2'b00) begin
            failures++;
            $display("FAIL spurious_state actual=%0d required=%0d", dut.r_state, ARB_IDLE);
        end
        ic_if.read = 1'b1; ic_if.write = 1'b1;
        ic_if.address = 16'h0A0A; ic_if.wdata = pat_3;
        tick();
        checks++;
        if ({mem_if.read, mem_if.write} !== 2'b01 || mem_if.address !== 16'h0A00 ||
            mem_if.wdata !== pat_3) begin
            failures++;
            $display("FAIL rw_write_wins actual=%b/%h required=01/0a00",
                     {mem_if.read, mem_if.write}, mem_if.address);
        end
        mem_if.resp = 1'b1;
        #1;
        checks++;
        if ({ic_if.resp, dc_if.resp} !== 2'b10) begin
            failures++;
            $display("FAIL rw_resp actual=%b required=10", {ic_if.resp, dc_if.resp});
        end
        tick();
        mem_if.resp = 1'b0;
        ic_if.read = 1'b0; ic_if.write = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        dc_if.read = 1'b1; dc_if.address = 16'h0600;
        tick();
        checks++;
        if (mem_if.read !== 1'b1 || dut.r_state !== ARB_D) begin
            failures++;
            $display("FAIL mid_pre actual=%b/%0d required=1/%0d", mem_if.read, dut.r_state, ARB_D);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_if.read !== 1'b0 || dut.r_state !== ARB_IDLE) begin
            failures++;
            $display("FAIL mid_reset actual=%b/%0d required=0/%0d", mem_if.read, dut.r_state, ARB_IDLE);
        end
        dc_if.read = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        mem_if.resp = 1'b1;
        #1;
        checks++;
        if ({ic_if.resp, dc_if.resp} !== 2'b00) begin
            failures++;
            $display("FAIL mid_no_resp actual=%b required=00", {ic_if.resp, dc_if.resp});
        end
        tick();
        mem_if.resp = 1'b0;
        #1;
        checks++;
        if ({mem_if.read, mem_if.write} !== 2'b00) begin
            failures++;
            $display("FAIL mid_idle actual=%b required=00", {mem_if.read, mem_if.write});
        end
    endtask

    initial begin
        pat_ab = {32{8'hAB}};
        pat_d  = {16{16'hD00D}};
        pat_1  = {8{32'h1111_2222}};
        pat_2  = {8{32'h3333_4444}};
        pat_3  = {8{32'h5A5A_C3C3}};
        test_reset();
        test_lone_i_read();
        test_tie();
        test_back_to_back();
        test_latch_stability();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
